// File: rtl/ms_timer_ctrl_pkg.sv
// Shared definitions for the millisecond timer: state encoding and prescaler defaults.
// Optional lap capture is enabled elsewhere with the MS_TIMER_LAP_EN macro.
package ms_timer_ctrl_pkg;

  localparam int TICK_DIV_DEFAULT = 100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD
  } state_t;

  // Prescaler counter width; a divide-by-one still needs a 1-bit register.
  function automatic int presc_width(input int div);
    if (div > 1) begin
      return $clog2(div);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ms_timer_ctrl_if.sv
// Control/status bundle between the millisecond timer and its user.
// With MS_TIMER_LAP_EN defined the bundle also carries Lap and Lap_Count.
interface ms_timer_ctrl_if #(
  parameter int COUNT_W = 8
);

  logic               Start;
  logic               Clear;
  logic [COUNT_W-1:0] Count;
  logic               Running;
  logic               Tick;
  logic               Ovf;
`ifdef MS_TIMER_LAP_EN
  logic               Lap;
  logic [COUNT_W-1:0] Lap_Count;

  modport master (
    output Start, Clear, Lap,
    input  Count, Running, Tick, Ovf, Lap_Count
  );

  modport slave (
    input  Start, Clear, Lap,
    output Count, Running, Tick, Ovf, Lap_Count
  );
`else
  modport master (
    output Start, Clear,
    input  Count, Running, Tick, Ovf
  );

  modport slave (
    input  Start, Clear,
    output Count, Running, Tick, Ovf
  );
`endif

endinterface

// File: rtl/ms_timer_ctrl_prescaler.sv
// Divide-by-TICK_DIV prescaler; tick flags the cycle on which the counter wraps.
module ms_prescaler
  import ms_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign tick      = en & at_last_s;

  // Count while enabled, wrap at LAST; holding en low freezes the partial millisecond.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr) begin
      cnt_r <= {PW{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + PW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ms_timer_ctrl.sv
// Start/stop millisecond timer with IDLE/RUN/HOLD control and sticky overflow.
// Define MS_TIMER_LAP_EN to add Lap edge capture into Lap_Count.
module ms_timer_ctrl
  import ms_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int COUNT_W  = 8
) (
  input  logic          CLK,
  input  logic          RST,
  ms_timer_ctrl_if.slave bus
);

  state_t             state_r;
  logic               start_q_r;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_nxt_s;
  logic               running_r;
  logic               tick_r;
  logic               ovf_r;
  logic               start_evt_s;
  logic               presc_en_s;
  logic               presc_clr_s;
  logic               wrap_s;

  assign start_evt_s = bus.Start & ~start_q_r;
  assign presc_en_s  = (state_r == RUN) & ~bus.Clear;
  assign presc_clr_s = bus.Clear | (state_r == IDLE);

  ms_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .en   (presc_en_s),
    .clr  (presc_clr_s),
    .tick (wrap_s)
  );

  // Post-update count for the current cycle, shared by the FSM and lap capture.
  always_comb begin
    count_nxt_s = count_r;
    if ((state_r == RUN) && wrap_s) begin
      count_nxt_s = count_r + COUNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Control FSM with registered Count/Running/Tick/Ovf; Clear outranks start events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      start_q_r <= bus.Start;
      count_r   <= {COUNT_W{1'b0}};
      running_r <= 1'b0;
      tick_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      start_q_r <= bus.Start;
      tick_r    <= 1'b0;
      if (bus.Clear) begin
        state_r   <= IDLE;
        count_r   <= {COUNT_W{1'b0}};
        running_r <= 1'b0;
        ovf_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            count_r <= {COUNT_W{1'b0}};
            if (start_evt_s) begin
              state_r   <= RUN;
              running_r <= 1'b1;
            end else begin
              state_r   <= IDLE;
              running_r <= 1'b0;
            end
          end
          RUN: begin
            // A wrap coinciding with a stop request still counts before holding.
            count_r <= count_nxt_s;
            tick_r  <= wrap_s;
            if (wrap_s && (count_r == {COUNT_W{1'b1}})) begin
              ovf_r <= 1'b1;
            end else begin
              ovf_r <= ovf_r;
            end
            if (start_evt_s) begin
              state_r   <= HOLD;
              running_r <= 1'b0;
            end else begin
              state_r   <= RUN;
              running_r <= 1'b1;
            end
          end
          HOLD: begin
            if (start_evt_s) begin
              state_r   <= RUN;
              running_r <= 1'b1;
            end else begin
              state_r   <= HOLD;
              running_r <= 1'b0;
            end
          end
          default: begin
            state_r   <= IDLE;
            count_r   <= {COUNT_W{1'b0}};
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Count   = count_r;
  assign bus.Running = running_r;
  assign bus.Tick    = tick_r;
  assign bus.Ovf     = ovf_r;

`ifdef MS_TIMER_LAP_EN
  logic               lap_q_r;
  logic [COUNT_W-1:0] lap_count_r;
  logic               lap_evt_s;

  assign lap_evt_s = bus.Lap & ~lap_q_r;

  // Lap capture only while running; the edge detector tracks Lap even in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lap_q_r     <= bus.Lap;
      lap_count_r <= {COUNT_W{1'b0}};
    end else begin
      lap_q_r <= bus.Lap;
      if (bus.Clear) begin
        lap_count_r <= {COUNT_W{1'b0}};
      end else if (lap_evt_s && (state_r == RUN)) begin
        lap_count_r <= count_nxt_s;
      end else begin
        lap_count_r <= lap_count_r;
      end
    end
  end

  assign bus.Lap_Count = lap_count_r;
`endif

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// Directed bench for ms_timer_ctrl at TICK_DIV=10, COUNT_W=8.
// Lap checks are compiled in when MS_TIMER_LAP_EN is defined.
module tb_ms_timer_ctrl;

  localparam int TD = 10;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 CLK = ~CLK;

  ms_timer_ctrl_if #(.COUNT_W(CW)) bus ();

  ms_timer_ctrl #(
    .TICK_DIV (TD),
    .COUNT_W  (CW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST       = 1'b1;
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
`ifdef MS_TIMER_LAP_EN
    bus.Lap   = 1'b0;
`endif
    step(3);
    check("rst_count",   32'(bus.Count),   32'd0);
    check("rst_running", 32'(bus.Running), 32'd0);
    check("rst_tick",    32'(bus.Tick),    32'd0);
    check("rst_ovf",     32'(bus.Ovf),     32'd0);
    RST = 1'b0;
    step(2);

    // First tick latency
    bus.Start = 1'b1; step(1);
    check("start_running", 32'(bus.Running), 32'd1);
    check("start_count0",  32'(bus.Count),   32'd0);
    bus.Start = 1'b0; step(9);
    check("pre_tick_count", 32'(bus.Count), 32'd0);
    check("pre_tick_tick",  32'(bus.Tick),  32'd0);
    step(1);
    check("tick1_count", 32'(bus.Count), 32'd1);
    check("tick1_tick",  32'(bus.Tick),  32'd1);
    step(1);
    check("tick1_pulse_end", 32'(bus.Tick), 32'd0);
    step(9);
    check("tick2_count", 32'(bus.Count), 32'd2);

    // Hold with a partial millisecond, then resume
    step(230);
    check("run_to_25", 32'(bus.Count), 32'd25);
    step(4);
    bus.Start = 1'b1; step(1);
    check("hold_running", 32'(bus.Running), 32'd0);
    bus.Start = 1'b0; step(100);
    check("hold_count", 32'(bus.Count), 32'd25);
    bus.Start = 1'b1; step(1);
    check("resume_running", 32'(bus.Running), 32'd1);
    bus.Start = 1'b0; step(4);
    check("resume_5cyc", 32'(bus.Count), 32'd25);
    step(1);
    check("resume_6cyc", 32'(bus.Count), 32'd26);
    check("resume_tick", 32'(bus.Tick),  32'd1);

    // Wrap and sticky overflow
    step(2290);
    check("count_255", 32'(bus.Count), 32'd255);
    check("ovf_before", 32'(bus.Ovf),  32'd0);
    step(10);
    check("wrap_count", 32'(bus.Count), 32'd0);
    check("wrap_ovf",   32'(bus.Ovf),   32'd1);
    step(10);
    check("ovf_sticky_count", 32'(bus.Count), 32'd1);
    check("ovf_sticky",       32'(bus.Ovf),   32'd1);
    bus.Clear = 1'b1; step(1);
    check("clr_count",   32'(bus.Count),   32'd0);
    check("clr_ovf",     32'(bus.Ovf),     32'd0);
    check("clr_running", 32'(bus.Running), 32'd0);
    bus.Clear = 1'b0; step(20);
    check("idle_count",   32'(bus.Count),   32'd0);
    check("idle_running", 32'(bus.Running), 32'd0);

    // Clear beats Start in RUN
    bus.Start = 1'b1; step(1);
    bus.Start = 1'b0; step(14);
    check("pre_clr_count", 32'(bus.Count), 32'd1);
    bus.Clear = 1'b1; bus.Start = 1'b1; step(1);
    check("clrstart_running", 32'(bus.Running), 32'd0);
    check("clrstart_count",   32'(bus.Count),   32'd0);
    bus.Clear = 1'b0; step(3);
    check("clrstart_stay_idle", 32'(bus.Running), 32'd0);
    bus.Start = 1'b0; step(1);

    // Stop request on the wrap cycle: count, then hold
    bus.Start = 1'b1; step(1);
    bus.Start = 1'b0; step(9);
    bus.Start = 1'b1; step(1);
    check("wrapstop_count",   32'(bus.Count),   32'd1);
    check("wrapstop_tick",    32'(bus.Tick),    32'd1);
    check("wrapstop_running", 32'(bus.Running), 32'd0);
    bus.Start = 1'b0; step(30);
    check("wrapstop_hold", 32'(bus.Count), 32'd1);
    bus.Clear = 1'b1; step(1);
    bus.Clear = 1'b0; step(1);

    // Start held high gives one transition
    bus.Start = 1'b1; step(50);
    check("held_running", 32'(bus.Running), 32'd1);
    check("held_count",   32'(bus.Count),   32'd4);
    bus.Start = 1'b0; step(1);

    // Start high across reset release
    RST = 1'b1; bus.Start = 1'b1; step(2);
    check("rst_hold_running", 32'(bus.Running), 32'd0);
    check("rst_hold_count",   32'(bus.Count),   32'd0);
    RST = 1'b0; step(5);
    check("rst_release_idle", 32'(bus.Running), 32'd0);
    bus.Start = 1'b0; step(1);

    // Reset on the wrap cycle emits no tick
    bus.Start = 1'b1; step(1);
    bus.Start = 1'b0; step(9);
    check("pre_rst_running", 32'(bus.Running), 32'd1);
    RST = 1'b1; step(1);
    check("midrun_rst_tick",    32'(bus.Tick),    32'd0);
    check("midrun_rst_count",   32'(bus.Count),   32'd0);
    check("midrun_rst_running", 32'(bus.Running), 32'd0);
    RST = 1'b0; step(2);

`ifdef MS_TIMER_LAP_EN
    bus.Start = 1'b1; step(1);
    bus.Start = 1'b0; step(70);
    check("lap_pre_count", 32'(bus.Count), 32'd7);
    bus.Lap = 1'b1; step(1);
    check("lap_capture", 32'(bus.Lap_Count), 32'd7);
    bus.Lap = 1'b0; step(30);
    check("lap_run_count", 32'(bus.Count),     32'd10);
    check("lap_kept",      32'(bus.Lap_Count), 32'd7);
    bus.Start = 1'b1; step(1);
    bus.Start = 1'b0; bus.Lap = 1'b1; step(1);
    bus.Lap = 1'b0; step(1);
    check("lap_hold_ignored", 32'(bus.Lap_Count), 32'd7);
    check("lap_hold_count",   32'(bus.Count),     32'd10);
    bus.Clear = 1'b1; step(1);
    check("lap_clear", 32'(bus.Lap_Count), 32'd0);
    bus.Clear = 1'b0; step(1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
